// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared sizes, entry layout and state encodings for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = 4;
    localparam int ROB_CNT_W = 5;

    typedef enum logic [1:0] {
        ROB_ALU    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_SIMPLE = 2'd3
    } rob_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_STORE = 2'd1,
        ST_FLUSH      = 2'd2
    } rob_state_e;

    typedef struct packed {
        logic      busy;
        logic      ready;
        rob_type_e typ;
        logic [4:0]  dest;
        logic [31:0] value;
        logic      pred_taken;
        logic      taken;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, result, commit, store and flush signals of the reorder buffer
interface reorder_buffer_if;
    import rob_pkg::*;

    logic                 rdy;
    logic                 alloc_valid;
    logic [1:0]           alloc_type;
    logic [4:0]           alloc_dest;
    logic [31:0]          alloc_value;
    logic                 alloc_pred_taken;
    logic [ROB_TAG_W-1:0] alloc_id;
    logic                 rob_full;
    logic                 simple_ins_commit;
    logic [ROB_TAG_W-1:0] simple_ins_rename;
    logic                 cdb_valid;
    logic [ROB_TAG_W-1:0] cdb_rename;
    logic [31:0]          cdb_value;
    logic                 cdb_taken;
    logic                 register_update_flag;
    logic [4:0]           register_commit_dest;
    logic [31:0]          register_commit_value;
    logic [ROB_TAG_W-1:0] rename_of_commit_ins;
    logic                 store_commit;
    logic [ROB_TAG_W-1:0] store_commit_id;
    logic                 store_done;
    logic                 rob_flush;
    logic [31:0]          flush_pc;

    modport slave (
        input  rdy, alloc_valid, alloc_type, alloc_dest, alloc_value, alloc_pred_taken,
        input  simple_ins_commit, simple_ins_rename, cdb_valid, cdb_rename, cdb_value, cdb_taken,
        input  store_done,
        output alloc_id, rob_full, register_update_flag, register_commit_dest,
        output register_commit_value, rename_of_commit_ins, store_commit, store_commit_id,
        output rob_flush, flush_pc
    );

    modport master (
        output rdy, alloc_valid, alloc_type, alloc_dest, alloc_value, alloc_pred_taken,
        output simple_ins_commit, simple_ins_rename, cdb_valid, cdb_rename, cdb_value, cdb_taken,
        output store_done,
        input  alloc_id, rob_full, register_update_flag, register_commit_dest,
        input  register_commit_value, rename_of_commit_ins, store_commit, store_commit_id,
        input  rob_flush, flush_pc
    );
endinterface

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping head/tail/count tracker producing full and empty
module rob_ptr
    import rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    output logic [ROB_TAG_W-1:0] head,
    output logic [ROB_TAG_W-1:0] tail,
    output logic                 full,
    output logic                 empty
);
    logic [ROB_TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + ROB_CNT_W'(push) - ROB_CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign full  = (count_q == ROB_CNT_W'(ROB_DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order retirement buffer with store handshake and mispredict flush
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    reorder_buffer_if.slave rob
);
    rob_state_e           state_q, state_d;
    rob_entry_t           ent_q [DEPTH];
    rob_entry_t           ent_d [DEPTH];
    rob_entry_t           head_ent;
    logic [ROB_TAG_W-1:0] head, tail;
    logic                 full, empty, push, pop, clear, flushing, head_ok, mispredict;

    logic                 upd_q, upd_d, sc_q, sc_d, flush_q, flush_d;
    logic [4:0]           cdest_q, cdest_d;
    logic [31:0]          cval_q, cval_d, fpc_q, fpc_d;
    logic [ROB_TAG_W-1:0] ctag_q, ctag_d, sid_q, sid_d;

    rob_ptr u_ptr (
        .clk(clk), .rst_n(rst_n), .rdy(rob.rdy), .push(push), .pop(pop), .clear(clear),
        .head(head), .tail(tail), .full(full), .empty(empty)
    );

    assign head_ent   = ent_q[head];
    assign flushing   = (state_q == ST_FLUSH);
    assign push       = rob.alloc_valid & ~full & ~flushing;
    assign head_ok    = ~empty & head_ent.busy & head_ent.ready;
    assign mispredict = (head_ent.taken != head_ent.pred_taken);

    // Retire clears busy last so it wins over a late CDB hit on the departing head.
    always_comb begin
        ent_d = ent_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end
        end else begin
            if (push) begin
                ent_d[tail] = '{busy: 1'b1, ready: 1'b0, typ: rob_type_e'(rob.alloc_type),
                                dest: rob.alloc_dest,
                                value: (rob.alloc_type == ROB_SIMPLE) ? rob.alloc_value : 32'h0,
                                pred_taken: rob.alloc_pred_taken, taken: 1'b0};
            end
            if (rob.simple_ins_commit && ent_q[rob.simple_ins_rename].busy)
                ent_d[rob.simple_ins_rename].ready = 1'b1;
            if (rob.cdb_valid && ent_q[rob.cdb_rename].busy) begin
                ent_d[rob.cdb_rename].ready = 1'b1;
                ent_d[rob.cdb_rename].value = rob.cdb_value;
                ent_d[rob.cdb_rename].taken = rob.cdb_taken;
            end
            if (pop) ent_d[head].busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (rob.rdy) begin
            ent_q <= ent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (head_ok) begin
                    case (head_ent.typ)
                        ROB_STORE:  state_d = ST_WAIT_STORE;
                        ROB_BRANCH: if (mispredict) state_d = ST_FLUSH;
                        default:    state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_STORE: if (rob.store_done) state_d = ST_IDLE;
            ST_FLUSH:      state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Commit, store and flush outputs are registered, so they appear the cycle after the decision.
    always_comb begin
        pop     = 1'b0;
        clear   = 1'b0;
        upd_d   = 1'b0;
        cdest_d = '0;
        cval_d  = '0;
        ctag_d  = '0;
        sc_d    = 1'b0;
        sid_d   = '0;
        flush_d = 1'b0;
        fpc_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (head_ok) begin
                    case (head_ent.typ)
                        ROB_STORE: begin
                            sc_d  = 1'b1;
                            sid_d = head;
                        end
                        ROB_BRANCH: begin
                            if (mispredict) begin
                                flush_d = 1'b1;
                                fpc_d   = head_ent.value;
                            end else begin
                                pop = 1'b1;
                            end
                        end
                        default: begin
                            pop     = 1'b1;
                            upd_d   = 1'b1;
                            cdest_d = head_ent.dest;
                            cval_d  = head_ent.value;
                            ctag_d  = head;
                        end
                    endcase
                end
            end
            ST_WAIT_STORE: begin
                if (rob.store_done) begin
                    pop = 1'b1;
                end else begin
                    sc_d  = 1'b1;
                    sid_d = head;
                end
            end
            ST_FLUSH: clear = 1'b1;
            default:  clear = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            upd_q   <= 1'b0;
            cdest_q <= '0;
            cval_q  <= '0;
            ctag_q  <= '0;
            sc_q    <= 1'b0;
            sid_q   <= '0;
            flush_q <= 1'b0;
            fpc_q   <= '0;
        end else if (rob.rdy) begin
            state_q <= state_d;
            upd_q   <= upd_d;
            cdest_q <= cdest_d;
            cval_q  <= cval_d;
            ctag_q  <= ctag_d;
            sc_q    <= sc_d;
            sid_q   <= sid_d;
            flush_q <= flush_d;
            fpc_q   <= fpc_d;
        end
    end

    assign rob.alloc_id              = tail;
    assign rob.rob_full              = full;
    assign rob.register_update_flag  = upd_q;
    assign rob.register_commit_dest  = cdest_q;
    assign rob.register_commit_value = cval_q;
    assign rob.rename_of_commit_ins  = ctag_q;
    assign rob.store_commit          = sc_q;
    assign rob.store_commit_id       = sid_q;
    assign rob.rob_flush             = flush_q;
    assign rob.flush_pc              = fpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against an in-order commit model
module tb_reorder_buffer;
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] value;
        logic [3:0]  tag;
    } commit_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      checks = 0;
    int      fails = 0;
    int      flush_cnt = 0;
    commit_t obs[$];

    reorder_buffer_if bus ();
    reorder_buffer #(.DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .rob(bus));

    always #5 clk = ~clk;

    task automatic tick();
        commit_t c;
        @(posedge clk);
        #1;
        if (bus.register_update_flag) begin
            c.dest  = bus.register_commit_dest;
            c.value = bus.register_commit_value;
            c.tag   = bus.rename_of_commit_ins;
            obs.push_back(c);
        end
        if (bus.rob_flush) flush_cnt++;
    endtask

    task automatic idle_inputs();
        bus.rdy = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_type = 2'd0;
        bus.alloc_dest = 5'd0;
        bus.alloc_value = 32'h0;
        bus.alloc_pred_taken = 1'b0;
        bus.simple_ins_commit = 1'b0;
        bus.simple_ins_rename = 4'd0;
        bus.cdb_valid = 1'b0;
        bus.cdb_rename = 4'd0;
        bus.cdb_value = 32'h0;
        bus.cdb_taken = 1'b0;
        bus.store_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete();
        flush_cnt = 0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] d, input logic [31:0] v, input logic p);
        bus.alloc_valid = 1'b1;
        bus.alloc_type = t;
        bus.alloc_dest = d;
        bus.alloc_value = v;
        bus.alloc_pred_taken = p;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic tk);
        bus.cdb_valid = 1'b1;
        bus.cdb_rename = tag;
        bus.cdb_value = v;
        bus.cdb_taken = tk;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.register_update_flag, bus.register_commit_dest, bus.register_commit_value,
             bus.rename_of_commit_ins} !== '0) begin
            fails++;
            $display("FAIL reset_commit_port: got flag=%0b rd=%0d val=%0h tag=%0d expected all 0",
                     bus.register_update_flag, bus.register_commit_dest, bus.register_commit_value,
                     bus.rename_of_commit_ins);
        end
        checks++;
        if ({bus.store_commit, bus.store_commit_id, bus.rob_flush, bus.flush_pc} !== '0) begin
            fails++;
            $display("FAIL reset_store_flush: got sc=%0b id=%0d flush=%0b pc=%0h expected all 0",
                     bus.store_commit, bus.store_commit_id, bus.rob_flush, bus.flush_pc);
        end
        checks++;
        if (bus.alloc_id !== 4'd0 || bus.rob_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_ptr: got alloc_id=%0d full=%0b expected 0 0", bus.alloc_id, bus.rob_full);
        end
    endtask

    task automatic test_in_order();
        commit_t e[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.alloc_id !== 4'(i)) begin
                fails++;
                $display("FAIL order_tag%0d: got %0d expected %0d", i, bus.alloc_id, i);
            end
            alloc(2'd0, 5'(5 + i), 32'h0, 1'b0);
        end
        cdb(4'd2, 32'h11, 1'b0);
        cdb(4'd0, 32'h22, 1'b0);
        cdb(4'd1, 32'h33, 1'b0);
        for (int c = 0; c < 20 && obs.size() < 3; c++) tick();
        repeat (3) tick();
        e[0] = '{dest: 5'd5, value: 32'h22, tag: 4'd0};
        e[1] = '{dest: 5'd6, value: 32'h33, tag: 4'd1};
        e[2] = '{dest: 5'd7, value: 32'h11, tag: 4'd2};
        checks++;
        if (obs.size() != 3) begin
            fails++;
            $display("FAIL order_count: got %0d commits expected 3", obs.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obs.size()) begin
                fails++;
                $display("FAIL order_commit%0d: got none expected rd=%0d val=%0h", i, e[i].dest, e[i].value);
            end else if (obs[i] !== e[i]) begin
                fails++;
                $display("FAIL order_commit%0d: got rd=%0d val=%0h tag=%0d expected rd=%0d val=%0h tag=%0d",
                         i, obs[i].dest, obs[i].value, obs[i].tag, e[i].dest, e[i].value, e[i].tag);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i + 1), 32'h0, 1'b0);
        checks++;
        if (bus.rob_full !== 1'b1 || bus.alloc_id !== 4'd0) begin
            fails++;
            $display("FAIL full_set: got full=%0b id=%0d expected 1 0", bus.rob_full, bus.alloc_id);
        end
        alloc(2'd0, 5'd30, 32'h0, 1'b0);
        checks++;
        if (bus.rob_full !== 1'b1 || bus.alloc_id !== 4'd0) begin
            fails++;
            $display("FAIL full_drop17: got full=%0b id=%0d expected 1 0", bus.rob_full, bus.alloc_id);
        end
        cdb(4'd0, 32'hAB, 1'b0);
        alloc(2'd0, 5'd31, 32'h0, 1'b0);
        checks++;
        if (bus.alloc_id !== 4'd0 || bus.rob_full !== 1'b0) begin
            fails++;
            $display("FAIL full_retire_drop: got id=%0d full=%0b expected 0 0", bus.alloc_id, bus.rob_full);
        end
        checks++;
        if (bus.register_update_flag !== 1'b1 || bus.rename_of_commit_ins !== 4'd0 ||
            bus.register_commit_value !== 32'hAB) begin
            fails++;
            $display("FAIL full_commit: got flag=%0b tag=%0d val=%0h expected 1 0 ab",
                     bus.register_update_flag, bus.rename_of_commit_ins, bus.register_commit_value);
        end
        alloc(2'd0, 5'd31, 32'h0, 1'b0);
        checks++;
        if (bus.alloc_id !== 4'd1 || bus.rob_full !== 1'b1) begin
            fails++;
            $display("FAIL full_realloc: got id=%0d full=%0b expected 1 1", bus.alloc_id, bus.rob_full);
        end
    endtask

    task automatic test_store();
        do_reset();
        alloc(2'd1, 5'd0, 32'h0, 1'b0);
        alloc(2'd0, 5'd9, 32'h0, 1'b0);
        bus.store_done = 1'b1;
        tick();
        bus.store_done = 1'b0;
        cdb(4'd0, 32'h100, 1'b0);
        checks++;
        if (bus.store_commit !== 1'b0) begin
            fails++;
            $display("FAIL store_early: got %0b expected 0", bus.store_commit);
        end
        cdb(4'd1, 32'h55, 1'b0);
        checks++;
        if (bus.store_commit !== 1'b1 || bus.store_commit_id !== 4'd0) begin
            fails++;
            $display("FAIL store_rise: got sc=%0b id=%0d expected 1 0", bus.store_commit, bus.store_commit_id);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.store_commit !== 1'b1 || bus.register_update_flag !== 1'b0) begin
                fails++;
                $display("FAIL store_hold%0d: got sc=%0b flag=%0b expected 1 0", i, bus.store_commit,
                         bus.register_update_flag);
            end
        end
        bus.store_done = 1'b1;
        tick();
        bus.store_done = 1'b0;
        checks++;
        if (bus.store_commit !== 1'b0 || bus.register_update_flag !== 1'b0) begin
            fails++;
            $display("FAIL store_done: got sc=%0b flag=%0b expected 0 0", bus.store_commit, bus.register_update_flag);
        end
        tick();
        checks++;
        if (bus.register_update_flag !== 1'b1 || bus.register_commit_dest !== 5'd9 ||
            bus.register_commit_value !== 32'h55 || bus.rename_of_commit_ins !== 4'd1) begin
            fails++;
            $display("FAIL store_next_commit: got flag=%0b rd=%0d val=%0h tag=%0d expected 1 9 55 1",
                     bus.register_update_flag, bus.register_commit_dest, bus.register_commit_value,
                     bus.rename_of_commit_ins);
        end
        bus.rdy = 1'b0;
        bus.alloc_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.register_update_flag !== 1'b1 || bus.alloc_id !== 4'd2) begin
            fails++;
            $display("FAIL rdy_freeze: got flag=%0b id=%0d expected 1 2", bus.register_update_flag, bus.alloc_id);
        end
        bus.alloc_valid = 1'b0;
        bus.rdy = 1'b1;
        tick();
        checks++;
        if (bus.register_update_flag !== 1'b0 || bus.alloc_id !== 4'd2) begin
            fails++;
            $display("FAIL rdy_resume: got flag=%0b id=%0d expected 0 2", bus.register_update_flag, bus.alloc_id);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        alloc(2'd2, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) alloc(2'd0, 5'(10 + i), 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) cdb(4'(i), 32'(i * 3), 1'b0);
        cdb(4'd0, 32'h1040, 1'b1);
        checks++;
        if (bus.rob_flush !== 1'b0) begin
            fails++;
            $display("FAIL flush_early: got %0b expected 0", bus.rob_flush);
        end
        tick();
        checks++;
        if (bus.rob_flush !== 1'b1 || bus.flush_pc !== 32'h1040) begin
            fails++;
            $display("FAIL flush_pulse: got flush=%0b pc=%0h expected 1 1040", bus.rob_flush, bus.flush_pc);
        end
        bus.alloc_valid = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_rename = 4'd1;
        bus.simple_ins_commit = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.rob_flush !== 1'b0 || bus.alloc_id !== 4'd0) begin
            fails++;
            $display("FAIL flush_after: got flush=%0b id=%0d expected 0 0", bus.rob_flush, bus.alloc_id);
        end
        repeat (8) tick();
        checks++;
        if (obs.size() != 0 || flush_cnt != 1 || bus.rob_full !== 1'b0) begin
            fails++;
            $display("FAIL flush_squash: got commits=%0d flushes=%0d full=%0b expected 0 1 0",
                     obs.size(), flush_cnt, bus.rob_full);
        end
        alloc(2'd0, 5'd20, 32'h0, 1'b0);
        cdb(4'd0, 32'h99, 1'b0);
        for (int c = 0; c < 10 && obs.size() < 1; c++) tick();
        checks++;
        if (obs.size() != 1 || obs[0] !== commit_t'{dest: 5'd20, value: 32'h99, tag: 4'd0}) begin
            fails++;
            $display("FAIL flush_restart: got commits=%0d expected one of rd=20 val=99 tag=0", obs.size());
        end
    endtask

    task automatic test_simple();
        do_reset();
        alloc(2'd3, 5'd3, 32'hDEAD, 1'b0);
        bus.simple_ins_commit = 1'b1;
        bus.simple_ins_rename = 4'd0;
        tick();
        bus.simple_ins_commit = 1'b0;
        alloc(2'd2, 5'd0, 32'h0, 1'b1);
        alloc(2'd0, 5'd4, 32'h0, 1'b0);
        cdb(4'd1, 32'h2000, 1'b1);
        cdb(4'd2, 32'h77, 1'b0);
        repeat (10) tick();
        checks++;
        if (obs.size() != 2 || flush_cnt != 0) begin
            fails++;
            $display("FAIL simple_count: got commits=%0d flushes=%0d expected 2 0", obs.size(), flush_cnt);
        end else begin
            checks++;
            if (obs[0] !== commit_t'{dest: 5'd3, value: 32'hDEAD, tag: 4'd0}) begin
                fails++;
                $display("FAIL simple_commit: got rd=%0d val=%0h tag=%0d expected 3 dead 0",
                         obs[0].dest, obs[0].value, obs[0].tag);
            end
            checks++;
            if (obs[1] !== commit_t'{dest: 5'd4, value: 32'h77, tag: 4'd2}) begin
                fails++;
                $display("FAIL branch_ok_commit: got rd=%0d val=%0h tag=%0d expected 4 77 2",
                         obs[1].dest, obs[1].value, obs[1].tag);
            end
        end
    endtask

    task automatic test_reset_in_wait_store();
        do_reset();
        alloc(2'd1, 5'd0, 32'h0, 1'b0);
        cdb(4'd0, 32'h8, 1'b0);
        tick();
        checks++;
        if (bus.store_commit !== 1'b1) begin
            fails++;
            $display("FAIL wrst_pre: got sc=%0b expected 1", bus.store_commit);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.store_commit, bus.store_commit_id, bus.register_update_flag, bus.rob_flush,
             bus.flush_pc, bus.alloc_id, bus.rob_full} !== '0) begin
            fails++;
            $display("FAIL wrst_async: got sc=%0b id=%0d flag=%0b flush=%0b alloc_id=%0d expected all 0",
                     bus.store_commit, bus.store_commit_id, bus.register_update_flag, bus.rob_flush, bus.alloc_id);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.store_commit !== 1'b0 || bus.alloc_id !== 4'd0) begin
            fails++;
            $display("FAIL wrst_idle: got sc=%0b id=%0d expected 0 0", bus.store_commit, bus.alloc_id);
        end
    endtask

    task automatic test_random();
        commit_t     exp_q[$];
        logic [3:0]  alu_tags[$];
        logic [3:0]  simple_tags[$];
        logic [31:0] vals[16];
        int          next_tag;
        do_reset();
        next_tag = 0;
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(1, 9);
            exp_q.delete();
            alu_tags.delete();
            simple_tags.delete();
            obs.delete();
            for (int i = 0; i < k; i++) begin
                commit_t c;
                bit      simple;
                simple  = 1'($urandom_range(0, 1));
                c.tag   = 4'(next_tag);
                c.dest  = 5'($urandom_range(0, 31));
                c.value = $urandom;
                vals[c.tag] = c.value;
                checks++;
                if (bus.alloc_id !== c.tag) begin
                    fails++;
                    $display("FAIL rand_tag r%0d i%0d: got %0d expected %0d", r, i, bus.alloc_id, c.tag);
                end
                alloc(simple ? 2'd3 : 2'd0, c.dest, simple ? c.value : 32'h0, 1'b0);
                exp_q.push_back(c);
                if (simple) simple_tags.push_back(c.tag);
                else        alu_tags.push_back(c.tag);
                next_tag = (next_tag + 1) % 16;
            end
            for (int i = alu_tags.size() - 1; i > 0; i--) begin
                int         j;
                logic [3:0] t;
                j = $urandom_range(0, i);
                t = alu_tags[i];
                alu_tags[i] = alu_tags[j];
                alu_tags[j] = t;
            end
            while (alu_tags.size() > 0 || simple_tags.size() > 0) begin
                if (alu_tags.size() > 0) begin
                    bus.cdb_valid = 1'b1;
                    bus.cdb_rename = alu_tags.pop_front();
                    bus.cdb_value = vals[bus.cdb_rename];
                end
                if (simple_tags.size() > 0) begin
                    bus.simple_ins_commit = 1'b1;
                    bus.simple_ins_rename = simple_tags.pop_back();
                end
                tick();
                bus.cdb_valid = 1'b0;
                bus.simple_ins_commit = 1'b0;
            end
            for (int c = 0; c < 40 && obs.size() < exp_q.size(); c++) tick();
            repeat (2) tick();
            checks++;
            if (obs.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand_count r%0d: got %0d commits expected %0d", r, obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand_commit r%0d i%0d: got rd=%0d val=%0h tag=%0d expected rd=%0d val=%0h tag=%0d",
                             r, i, obs[i].dest, obs[i].value, obs[i].tag, exp_q[i].dest, exp_q[i].value, exp_q[i].tag);
                end
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_in_order();
        test_full();
        test_store();
        test_branch_flush();
        test_simple();
        test_reset_in_wait_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer between dispatch and the register file. It gives each dispatched instruction a 4-bit rename tag and records CDB results against that tag. It retires instructions in program order, one per cycle, driving the register-file commit port. It also serialises store retirement with the load/store buffer and resolves branch mispredictions by flushing the whole pipeline.

## Interface
Parameters:
- DEPTH, 16: entry count; fixed by the 4-bit rename tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_type  in  2  0 = ALU/load, 1 = store, 2 = branch, 3 = simple (result known at dispatch).
- alloc_dest  in  5  destination register; ignored for store/branch.
- alloc_value  in  32  result for simple instructions.
- alloc_pred_taken  in  1  branch prediction for type 2.
- alloc_id  out  4  tag the next allocation receives; equals tail pointer, combinational.
- rob_full  out  1  count == 16, registered.
- simple_ins_commit  in  1  register file confirms a simple rename.
- simple_ins_rename  in  4  tag to mark ready.
- cdb_valid  in  1  result broadcast.
- cdb_rename  in  4  producing tag.
- cdb_value  in  32  result; for branches, the correct next PC.
- cdb_taken  in  1  actual branch outcome.
- register_update_flag  out  1  one-cycle commit pulse to the register file.
- register_commit_dest  out  5  committed rd.
- register_commit_value  out  32  committed value.
- rename_of_commit_ins  out  4  committed tag.
- store_commit  out  1  level; head store may write memory.
- store_commit_id  out  4  tag of that store.
- store_done  in  1  load/store buffer finished the head store.
- rob_flush  out  1  one-cycle flush pulse; drives register_flush and the RS/LSB flush.
- flush_pc  out  32  redirect target, valid with rob_flush.

## Operation
- Entry fields: busy, ready, type, dest, value, pred_taken, taken.
- Pointers: head and tail are 4 bits and wrap 15→0. count is 5 bits and ranges 0..16.
- Allocation:
  - Accepted when alloc_valid, !rob_full and no flush this cycle.
  - The entry at tail is written with busy = 1 and ready = 0.
  - For type 3, value = alloc_value.
  - tail increments.
- Ready marking:
  - simple_ins_commit sets ready on entry simple_ins_rename.
  - cdb_valid sets ready on entry cdb_rename and latches value and taken.
  - Both may hit different entries in the same cycle.
- FSM states:
  - IDLE:
    - Head busy and ready, type 0/3: pulse register_update_flag with dest, value and tag; retire the head.
    - Type 2, taken == pred_taken: retire silently.
    - Type 2, mispredicted: go to FLUSH.
    - Type 1: assert store_commit and go to WAIT_STORE.
  - WAIT_STORE: hold store_commit high. On store_done, drop it, retire the head and return to IDLE.
  - FLUSH (one cycle):
    - rob_flush = 1 and flush_pc = head value.
    - All busy bits cleared; head = tail = count = 0.
    - Return to IDLE.
- Retire: clears busy and increments head.
- Count update: count += accepted allocation − retire. A simultaneous allocation and retirement leaves count unchanged.
- Full condition: rob_full is computed from the registered count. At count 16, an allocation in the same cycle as a retirement is still rejected.
- Entries with dest x0 commit normally; the register file discards the write.
- A CDB write to a non-busy tag is ignored.

## Timing
- Reset values: every output 0; head = tail = count = 0; all busy = 0; FSM = IDLE.
- Result to commit: the earliest commit is the cycle after the CDB write that makes the head ready. register_update_flag is high in that following cycle.
- Commit rate: at most one retirement per cycle.
- Store handshake: store_commit rises one cycle after the store reaches the ready head. The entry retires on the edge where store_done is sampled high. A store_done received outside WAIT_STORE is ignored.
- Flush timing: rob_flush is asserted exactly one cycle, the cycle after the mispredicted branch is at the head and ready.
- During the flush cycle:
  - Allocation, CDB input and simple_ins_commit are ignored.
  - Allocation resumes at tag 0 in the next cycle.
- rdy low freezes the FSM, pointers and outputs, including pulses.
- Reset asserted mid-operation (for example in WAIT_STORE) returns immediately to reset values.

## Structure
- Package rob_pkg: ROB_DEPTH = 16, ROB_TAG_W = 4, the 2-bit type enum (ROB_ALU, ROB_STORE, ROB_BRANCH, ROB_SIMPLE), and the FSM state enum.
- The entry array stays inline.
- One natural sub-module: rob_ptr, a wrapping head/tail/count tracker that produces full and empty.

## Test plan
- After reset, allocate 3 ALU entries with dest x5, x6, x7. Expect tags 0, 1, 2. CDB results arrive for tags 2, 0, 1 with values 0x11, 0x22, 0x33. Expect commits in order: x5 = 0x22, x6 = 0x33, x7 = 0x11.
- Allocate 16 entries: rob_full = 1 and a 17th alloc is dropped. Commit one entry while allocating in the same cycle: the allocation is still dropped. The next cycle's allocation receives tag 0.
- Store at head, ready: store_commit = 1 with id 0, held for 3 cycles with no retirement. store_done pulses: the entry retires and the next ALU entry commits the following cycle.
- Branch with pred 0, CDB taken = 1, value 0x1040, followed by 4 younger entries: rob_flush pulses once with flush_pc = 0x1040. The younger entries never commit, count = 0, and the next alloc_id = 0.
- Simple instruction with alloc_value 0xDEAD and simple_ins_commit: it commits with value 0xDEAD without any CDB write.
- Drop rst_n while in WAIT_STORE: all outputs go to 0 immediately and the FSM returns to IDLE.
